// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the packet-locking round-robin arbiter.
// RR_ARB_WEIGHT_EN enables weighted round robin in rr_arb_pkt.
package rr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } rr_arb_state_e;

    // Width of a grant index; a single requester still needs one bit.
    function automatic int rr_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_pkt_pick.sv
// Combinational round-robin pick: first request after ptr, wrapping modulo N.
// Uses a double-width rotate followed by a lowest-bit priority encoder.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = rr_idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [IDW:0]     w_start;
    logic [IDW:0]     w_off;
    logic [IDW:0]     w_sum;
    logic [2*N-1:0]   w_dbl;
    logic [2*N-1:0]   w_rot;
    logic [N-1:0]     w_win;

    always_comb begin
        // N need not be a power of two, so wrap the start point by compare.
        w_start = ({1'b0, ptr} >= (IDW+1)'(N-1)) ? '0 : {1'b0, ptr} + (IDW+1)'(1);
        w_dbl   = {req, req};
        w_rot   = w_dbl >> w_start;
        w_win   = w_rot[N-1:0];
        w_off   = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (w_win[k]) w_off = (IDW+1)'(k);
        end
        w_sum = w_start + w_off;
        if (w_sum >= (IDW+1)'(N)) w_sum = w_sum - (IDW+1)'(N);
        idx  = w_sum[IDW-1:0];
        pick = any ? (N'(1) << idx) : '0;
    end

    assign any = |req;

endmodule

// File: rtl/rr_arb_pkt.sv
// N-way round-robin arbiter holding the grant for a whole multi-beat packet.
// Define RR_ARB_WEIGHT_EN for weighted round robin (adds the weight port).
module rr_arb_pkt
    import rr_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = rr_idw(N),
    parameter int WW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_last,
    input  logic            out_ready,
`ifdef RR_ARB_WEIGHT_EN
    input  logic [N*WW-1:0] weight,
`endif
    output logic [N-1:0]    gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_vld,
    output logic            fire
);

    rr_arb_state_e  r_state, w_nstate;
    logic [N-1:0]   r_gnt, w_gnt_n;
    logic [IDW-1:0] r_gnt_id, w_gnt_id_n;
    logic [IDW-1:0] r_ptr, w_ptr_n;
    logic [IDW-1:0] w_pick_ptr;
    logic [N-1:0]   w_pick;
    logic [IDW-1:0] w_pick_idx;
    logic           w_any;
    logic           w_fire;
    logic           w_eop;
    logic           w_keep;

    // A weight wider than zero bits is required for the packet counter.
    if (WW < 1) begin : g_ww_invalid
    end

    // In LOCK the pick is only consumed at end of packet, when the pointer
    // is about to become the current winner.
    assign w_pick_ptr = (r_state == LOCK) ? r_gnt_id : r_ptr;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req  (req),
        .ptr  (w_pick_ptr),
        .pick (w_pick),
        .idx  (w_pick_idx),
        .any  (w_any)
    );

    assign w_fire  = (|r_gnt) & req[r_gnt_id] & out_ready;
    assign w_eop   = w_fire & req_last[r_gnt_id];
    assign fire    = w_fire;
    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = |r_gnt;

`ifdef RR_ARB_WEIGHT_EN
    logic [WW-1:0] r_wcnt, w_wcnt_n;
    logic [WW-1:0] w_wraw;
    logic [WW:0]   w_weff;

    always_comb begin
        w_wraw = weight[int'(r_gnt_id)*WW +: WW];
        w_weff = (w_wraw == '0) ? (WW+1)'(1) : {1'b0, w_wraw};
        w_keep = (({1'b0, r_wcnt} + (WW+1)'(1)) < w_weff) & req[r_gnt_id];
    end

    always_comb begin
        w_wcnt_n = r_wcnt;
        if (r_state == LOCK && w_eop) w_wcnt_n = w_keep ? r_wcnt + WW'(1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wcnt <= '0;
        else     r_wcnt <= w_wcnt_n;
    end
`else
    assign w_keep = 1'b0;
`endif

    always_comb begin
        w_nstate   = r_state;
        w_gnt_n    = r_gnt;
        w_gnt_id_n = r_gnt_id;
        w_ptr_n    = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_gnt_n    = w_pick;
                    w_gnt_id_n = w_pick_idx;
                    w_nstate   = LOCK;
                end
            end
            LOCK: begin
                // Non-last beats and stalls (including bubbles) hold the grant.
                if (w_eop && !w_keep) begin
                    w_ptr_n = r_gnt_id;
                    if (w_any) begin
                        w_gnt_n    = w_pick;
                        w_gnt_id_n = w_pick_idx;
                    end else begin
                        w_gnt_n  = '0;
                        w_nstate = IDLE;
                    end
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= IDW'(N-1);
        end else begin
            r_state  <= w_nstate;
            r_gnt    <= w_gnt_n;
            r_gnt_id <= w_gnt_id_n;
            r_ptr    <= w_ptr_n;
        end
    end

endmodule

// File: tb/tb_rr_arb_pkt.sv
// Directed bench for rr_arb_pkt: N=4 and N=5 instances, plus N=2 weighted
// instance when RR_ARB_WEIGHT_EN is defined.
module tb_rr_arb_pkt;

    logic       clk;
    logic       rst;
    int         total;
    int         bad;

    logic [3:0] req, last;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] gid;
    logic       gv, fire;

    logic [4:0] req5, last5;
    logic       rdy5;
    logic [4:0] gnt5;
    logic [2:0] gid5;
    logic       gv5, fire5;

    rr_arb_pkt #(.N(4)) u0 (
        .clk(clk), .rst(rst), .req(req), .req_last(last), .out_ready(rdy),
`ifdef RR_ARB_WEIGHT_EN
        .weight(16'h1111),
`endif
        .gnt(gnt), .gnt_id(gid), .gnt_vld(gv), .fire(fire)
    );

    rr_arb_pkt #(.N(5)) u5 (
        .clk(clk), .rst(rst), .req(req5), .req_last(last5), .out_ready(rdy5),
`ifdef RR_ARB_WEIGHT_EN
        .weight(20'h11111),
`endif
        .gnt(gnt5), .gnt_id(gid5), .gnt_vld(gv5), .fire(fire5)
    );

`ifdef RR_ARB_WEIGHT_EN
    logic [1:0] reqw, lastw, gntw;
    logic [0:0] gidw;
    logic       gvw, firew;
    logic [7:0] wts;

    rr_arb_pkt #(.N(2)) uw (
        .clk(clk), .rst(rst), .req(reqw), .req_last(lastw), .out_ready(1'b1),
        .weight(wts), .gnt(gntw), .gnt_id(gidw), .gnt_vld(gvw), .fire(firew)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        req = '0; last = '0; rdy = 1'b0;
        req5 = '0; last5 = '0; rdy5 = 1'b0;
`ifdef RR_ARB_WEIGHT_EN
        reqw = '0; lastw = '0; wts = {4'd2, 4'd3};
`endif
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gid", 32'(gid), 32'h0);
        chk("rst_vld", 32'(gv), 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_vld", 32'(gv), 32'h0);

        // Single-beat packets from everyone: one grant per cycle 0,1,2,3,0.
        req = 4'b1111; last = 4'b1111; rdy = 1'b1;
        tick();
        chk("rr_g0", 32'(gid), 32'd0);
        chk("rr_onehot0", 32'(gnt), 32'b0001);
        chk("rr_fire0", 32'(fire), 32'd1);
        tick(); chk("rr_g1", 32'(gid), 32'd1);
        tick(); chk("rr_g2", 32'(gid), 32'd2);
        tick(); chk("rr_g3", 32'(gid), 32'd3);
        tick(); chk("rr_g0b", 32'(gid), 32'd0);

        // Requester 2 sends a 3-beat packet with a stall in the middle.
        tick(); chk("pk_g1", 32'(gid), 32'd1);
        tick(); chk("pk_g2", 32'(gid), 32'd2);
        last = 4'b0000;
        #1; chk("pk_fire_b1", 32'(fire), 32'd1);
        tick(); chk("pk_hold_b1", 32'(gid), 32'd2);
        rdy = 1'b0;
        #1; chk("pk_stall_nofire", 32'(fire), 32'd0);
        tick(); chk("pk_hold_stall", 32'(gid), 32'd2);
        rdy = 1'b1;
        tick(); chk("pk_hold_b2", 32'(gid), 32'd2);
        last = 4'b1111;
        tick();
        chk("pk_next3", 32'(gid), 32'd3);
        chk("pk_onehot3", 32'(gnt), 32'b1000);

        // Granted requester 0 drops req for two cycles; requester 3 waits.
        tick(); chk("bub_g0", 32'(gid), 32'd0);
        req = 4'b1001; last = 4'b0000;
        tick(); chk("bub_hold_b1", 32'(gid), 32'd0);
        req = 4'b1000;
        #1; chk("bub_nofire_a", 32'(fire), 32'd0);
        tick(); chk("bub_hold_a", 32'(gid), 32'd0);
        chk("bub_nofire_b", 32'(fire), 32'd0);
        tick(); chk("bub_hold_b", 32'(gid), 32'd0);
        req = 4'b1001; last = 4'b0001;
        #1; chk("bub_resume_fire", 32'(fire), 32'd1);
        tick(); chk("bub_then3", 32'(gid), 32'd3);

        // Move the grant to requester 1, then reset mid-packet.
        req = 4'b1010; last = 4'b1010;
        tick(); chk("rs_g1", 32'(gid), 32'd1);
        last = 4'b0000;
        rst = 1'b1;
        #1;
        chk("rs_async_gnt", 32'(gnt), 32'h0);
        chk("rs_async_vld", 32'(gv), 32'h0);
        chk("rs_async_gid", 32'(gid), 32'h0);
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tick(); chk("rs_idle", 32'(gv), 32'h0);
        req = 4'b0010;
        tick();
        chk("rs_regrant", 32'(gid), 32'd1);
        chk("rs_regrant_oh", 32'(gnt), 32'b0010);

        // N=5 wrap from ptr=4 after reset, then a requester re-winning itself.
        req5 = 5'b10001; last5 = 5'b11111; rdy5 = 1'b1;
        tick();
        chk("n5_wrap0", 32'(gid5), 32'd0);
        chk("n5_onehot0", 32'(gnt5), 32'b00001);
        tick(); chk("n5_g4", 32'(gid5), 32'd4);
        req5 = 5'b10000;
        tick(); chk("n5_self4", 32'(gid5), 32'd4);
        req5 = 5'b10001;
        tick(); chk("n5_wrap0b", 32'(gid5), 32'd0);

`ifdef RR_ARB_WEIGHT_EN
        // Weights {2,3}: requester 0 gets three packets, requester 1 two.
        begin
            logic [9:0] exp_pat;
            exp_pat = 10'b1100011000;
            reqw = 2'b11; lastw = 2'b11;
            for (int i = 0; i < 10; i++) begin
                tick();
                chk($sformatf("wrr_%0d", i), 32'(gidw), 32'(exp_pat[i]));
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arb_pkt.md
# rr_arb_pkt

Parametrised N-way round-robin arbiter with packet locking, the successor to the fixed 4-way `busy`-gated arbiter in `hw/core/lib`. It grants one requester at a time, holds the grant across a multi-beat packet until that requester's last beat is accepted downstream, then rotates priority. Grants are registered, and a new packet can follow on the next cycle with no idle cycle in between. It sits between N warp/LSU request sources and a single shared downstream port.

## Interface
- `N`, default 4: number of requesters, N ≥ 1.
- `IDW`, default `(N>1)?$clog2(N):1`: width of the grant index.
- `WW`, default 4: width of each per-requester weight. Used only when `RR_ARB_WEIGHT_EN` is defined.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `req` input N: per-requester beat valid.
- `req_last` input N: the current beat of requester i is the last beat of its packet.
- `out_ready` input 1: downstream accepts the presented beat.
- `gnt` output N: one-hot grant, registered.
- `gnt_id` output IDW: binary index of the granted requester, registered.
- `gnt_vld` output 1: a grant is held (`|gnt`).
- `fire` output 1: combinational, `gnt_vld & req[gnt_id] & out_ready`.
- `weight` input N*WW: requester i weight in bits `[i*WW +: WW]`. Present only with `RR_ARB_WEIGHT_EN`.

## Operation
- State machine with two states, IDLE and LOCK, plus a pointer `ptr` (IDW bits) that holds the index of the last winner.
- Reset values:
  - state = IDLE
  - `gnt` = 0, `gnt_id` = 0, `gnt_vld` = 0
  - `ptr` = N-1, so requester 0 has top priority first
  - weight counter = 0
- Pick function: the first requester with `req` set, searching from `ptr+1` upward and wrapping modulo N. The requester at `ptr` itself has the lowest priority. N need not be a power of two, so the wrap is an explicit compare, not a bit truncation.
- IDLE:
  - If `|req`, register the pick into `gnt`/`gnt_id` and go to LOCK.
  - Otherwise stay in IDLE.
- LOCK, by condition on the current cycle:
  - `fire & ~req_last[gnt_id]`: hold the grant.
  - `fire & req_last[gnt_id]`: end of packet. Set `ptr <= gnt_id`. If `|req` (computed with the updated pointer), register the new pick and stay in LOCK. Otherwise clear `gnt` and go to IDLE.
  - No `fire`, either because `out_ready`=0 or because `req[gnt_id]`=0: hold the grant unchanged. A granted requester that drops `req` mid-packet keeps the port (bubble beats). It is never preempted.
- Simultaneous events:
  - Requests from other sources arriving during LOCK do not disturb the grant.
  - Requests arriving in the same cycle as an end-of-packet fire are included in the new pick.
- Single-beat packets: `req_last`=1 on the first beat, so arbitration happens every beat.
- N=1: the pick is always 0 and `ptr` stays 0.

## Timing
- Grant latency from IDLE: `req` sampled at cycle t gives `gnt` valid at t+1.
- Back-to-back: last-beat fire at cycle t gives the next winner's `gnt` at t+1, with no idle cycle.
- Last-beat fire at t with no requests pending: `gnt`=0 and state IDLE at t+1.
- `fire` has zero latency and is combinational from `req`, `out_ready` and registered state.
- `rst` asserted mid-packet: all outputs clear asynchronously. After release, arbitration restarts from `ptr`=N-1. Any partial packet is abandoned.

## Configuration
- `RR_ARB_WEIGHT_EN` defined (weighted round robin):
  - Adds the `weight` port and a WW-bit packet counter `wcnt`.
  - On a last-beat fire:
    - If `wcnt+1 < weight[gnt_id]` and `req[gnt_id]`=1: keep the same grant, `wcnt` increments, `ptr` is unchanged.
    - Otherwise: rotate as described in Operation, with `wcnt` reset to 0.
  - Weight 0 is treated as 1.
- `RR_ARB_WEIGHT_EN` undefined: no `weight` port and no counter. Behaviour is exactly as in Operation, equivalent to every weight being 1.

## Structure
- Package `rr_arb_pkg`:
  - state enum typedef `rr_arb_state_e` (IDLE, LOCK)
  - helper function for the default IDW
- Sub-module `rr_pick`, combinational:
  - Inputs: `req[N]`, `ptr[IDW]`.
  - Outputs: one-hot pick, binary index, `any`.
  - Implemented as a double-width rotate plus a priority encoder.
  - Instantiated once in `rr_arb_pkt`.

## Test plan
- N=4, reset, then `req`=4'b1111 with all `req_last`=1 and `out_ready`=1 continuously: expected grant order 0,1,2,3,0, one per cycle, no idle cycles.
- N=4: requester 2 sends a 3-beat packet while `req`=4'b1111, and `out_ready` is low on the middle cycle. Expected: `gnt_id`=2 held for 4 cycles, then `gnt_id`=3.
- N=5 (not a power of two): `ptr`=4 with `req`=5'b00001. Expected `gnt_id`=0 (wrap). With `req`=5'b10000, expected `gnt_id`=4, granted itself last.
- Assert `rst` during LOCK with `gnt_id`=1: `gnt`=0 immediately. After release with `req`=4'b0010, `gnt_id`=1 one cycle later.
- `RR_ARB_WEIGHT_EN`, N=2, `weight` = {2, 3}, both requesting single-beat packets continuously. Expected grant pattern 0,0,0,1,1,0,0,0,1,1…
- Granted requester drops `req` for 2 cycles mid-packet while requester 3 requests: expected no `fire`, grant unchanged, and the packet resumes and completes before requester 3 is granted.
